// File: rtl/cus19_pkg.sv
// Shared encodings and field positions for the CUS19 19-bit CPU.
// Optional rotate cipher for ENC/DEC: define CUS19_ROT_CIPHER_EN.
package cus19_pkg;

  localparam logic [2:0] OP_R = 3'b000;
  localparam logic [2:0] OP_M = 3'b001;
  localparam logic [2:0] OP_J = 3'b010;
  localparam logic [2:0] OP_B = 3'b011;
  localparam logic [2:0] OP_S = 3'b100;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_MUL = 4'b0010;
  localparam logic [3:0] F_AND = 4'b0011;
  localparam logic [3:0] F_OR  = 4'b0100;
  localparam logic [3:0] F_XOR = 4'b1000;

  localparam logic [1:0] J_JMP  = 2'b00;
  localparam logic [1:0] J_CALL = 2'b01;
  localparam logic [1:0] J_RET  = 2'b10;
  localparam logic [1:0] J_NOP  = 2'b11;

  localparam logic M_ST  = 1'b0;
  localparam logic M_LD  = 1'b1;
  localparam logic B_BEQ = 1'b0;
  localparam logic B_BNE = 1'b1;
  localparam logic S_ENC = 1'b0;
  localparam logic S_DEC = 1'b1;

  localparam int OP_HI = 2;
  localparam int OP_LO = 0;

  localparam int R_RD_HI  = 18;
  localparam int R_RD_LO  = 15;
  localparam int R_RS1_HI = 14;
  localparam int R_RS1_LO = 11;
  localparam int R_RS2_HI = 10;
  localparam int R_RS2_LO = 7;
  localparam int R_FN_HI  = 6;
  localparam int R_FN_LO  = 3;

  localparam int M_ADDR_HI = 18;
  localparam int M_ADDR_LO = 8;
  localparam int M_REG_HI  = 7;
  localparam int M_REG_LO  = 4;
  localparam int M_SEL     = 3;

  localparam int J_TGT_HI = 15;
  localparam int J_TGT_LO = 5;
  localparam int J_SUB_HI = 4;
  localparam int J_SUB_LO = 3;

  localparam int B_TGT_HI = 18;
  localparam int B_TGT_LO = 12;
  localparam int B_RS1_HI = 11;
  localparam int B_RS1_LO = 8;
  localparam int B_RS2_HI = 7;
  localparam int B_RS2_LO = 4;
  localparam int B_SEL    = 3;

  localparam int S_RA_HI = 11;
  localparam int S_RA_LO = 8;
  localparam int S_RB_HI = 7;
  localparam int S_RB_LO = 4;
  localparam int S_SEL   = 3;

  function automatic logic [7:0] cus19_enc(
    input logic [7:0] x,
    input logic [7:0] k
  );
    logic [7:0] t;
    t = x ^ k;
`ifdef CUS19_ROT_CIPHER_EN
    return {t[6:0], t[7]};
`else
    return t;
`endif
  endfunction

  function automatic logic [7:0] cus19_dec(
    input logic [7:0] y,
    input logic [7:0] k
  );
`ifdef CUS19_ROT_CIPHER_EN
    return {y[0], y[7:1]} ^ k;
`else
    return y ^ k;
`endif
  endfunction

endpackage

// File: rtl/cus19_alu.sv
// CUS19 R-type ALU: zero-extended operands, double-width result.
// valid drops for undefined funct so the caller can skip writeback.
module cus19_alu
  import cus19_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input  logic [3:0]              funct,
  input  logic [Data_Width-1:0]   a,
  input  logic [Data_Width-1:0]   b,
  output logic [2*Data_Width-1:0] result,
  output logic                    valid
);

  logic [2*Data_Width-1:0] ax;
  logic [2*Data_Width-1:0] bx;

  assign ax = {{Data_Width{1'b0}}, a};
  assign bx = {{Data_Width{1'b0}}, b};

  always_comb begin
    result = '0;
    valid  = 1'b1;
    case (funct)
      F_ADD:   result = ax + bx;
      F_SUB:   result = ax - bx;
      F_MUL:   result = ax * bx;
      F_AND:   result = ax & bx;
      F_OR:    result = ax | bx;
      F_XOR:   result = ax ^ bx;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/cus19_mem.sv
// CUS19 storage: instruction ROM, register file and data RAM.
// Reads are combinational; contents have no reset (backdoor loaded).
module cus19_imem #(
  parameter int Addr_Width = 11,
  parameter int Word_Width = 19
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [Addr_Width-1:0] waddr,
  input  logic [Word_Width-1:0] wdata,
  input  logic [Addr_Width-1:0] addr,
  output logic [Word_Width-1:0] data
);

  logic [Word_Width-1:0] mem [2**Addr_Width];

  // Program-load port; tied off in the CPU top.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign data = mem[addr];

endmodule

module cus19_regfile #(
  parameter int Addr_Width = 4,
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic [Addr_Width-1:0] ra_addr,
  input  logic [Addr_Width-1:0] rb_addr,
  output logic [Data_Width-1:0] ra_data,
  output logic [Data_Width-1:0] rb_data,
  input  logic                  we,
  input  logic [Addr_Width-1:0] waddr,
  input  logic [Data_Width-1:0] wdata
);

  logic [Data_Width-1:0] reg_file [2**Addr_Width];

  always_ff @(posedge clk) begin
    if (we) reg_file[waddr] <= wdata;
  end

  assign ra_data = reg_file[ra_addr];
  assign rb_data = reg_file[rb_addr];

endmodule

module cus19_dmem #(
  parameter int Addr_Width = 11,
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic [Addr_Width-1:0] raddr,
  output logic [Data_Width-1:0] rdata,
  input  logic                  we,
  input  logic [Addr_Width-1:0] waddr,
  input  logic [Data_Width-1:0] wdata
);

  logic [Data_Width-1:0] data_mem [2**Addr_Width];

  always_ff @(posedge clk) begin
    if (we) data_mem[waddr] <= wdata;
  end

  assign rdata = data_mem[raddr];

endmodule

// File: rtl/cus19_cpu_top.sv
// CUS19 single-cycle CPU: one 19-bit instruction per clock.
// ENC/DEC flavour selected by CUS19_ROT_CIPHER_EN (see cus19_pkg).
module cus19_cpu_top
  import cus19_pkg::*;
#(
  parameter int         PC_Width       = 11,
  parameter int         Stack_Depth    = 8,
  parameter int         Instr_Width    = 19,
  parameter int         Data_Width     = 8,
  parameter int         Reg_Addr_Width = 4,
  parameter logic [7:0] key            = 8'hA5
) (
  input  logic                    cus19_clk_in,
  input  logic                    cus19_rst_in,
  output logic [2*Data_Width-1:0] alu_result_out,
  output logic [2*Data_Width-1:0] ld_result_out
);

  localparam int SP_W  = $clog2(Stack_Depth + 1);
  localparam int IDX_W = $clog2(Stack_Depth);
  localparam int PAD_D = PC_Width - Data_Width;
  localparam int PAD_B = PC_Width - (B_TGT_HI - B_TGT_LO + 1);

  logic                    clk;
  logic                    rst_n;
  logic [PC_Width-1:0]     pc;
  logic [PC_Width-1:0]     pc_inc;
  logic [PC_Width-1:0]     pc_next;
  logic [SP_W-1:0]         sp;
  logic [PC_Width-1:0]     stack [Stack_Depth];
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;

  logic [Instr_Width-1:0]  instr;
  logic [2:0]              op;
  logic                    is_r;
  logic                    is_m;
  logic                    is_j;
  logic                    is_b;
  logic                    is_s;

  logic [Reg_Addr_Width-1:0] ra_addr;
  logic [Reg_Addr_Width-1:0] rb_addr;
  logic [Data_Width-1:0]     ra_data;
  logic [Data_Width-1:0]     rb_data;
  logic                      rf_we;
  logic [Reg_Addr_Width-1:0] rf_waddr;
  logic [Data_Width-1:0]     rf_wdata;

  logic [PC_Width-1:0]     dm_raddr;
  logic [Data_Width-1:0]   dm_rdata;
  logic                    dm_we;
  logic [PC_Width-1:0]     dm_waddr;
  logic [Data_Width-1:0]   dm_wdata;
  logic [Data_Width-1:0]   s_data;

  logic [2*Data_Width-1:0] alu_res;
  logic                    alu_valid;
  logic                    alu_we;
  logic                    ld_we;
  logic                    rs_eq;
  logic                    br_taken;

  assign clk   = cus19_clk_in;
  assign rst_n = cus19_rst_in;

  assign op   = instr[OP_HI:OP_LO];
  assign is_r = (op == OP_R);
  assign is_m = (op == OP_M);
  assign is_j = (op == OP_J);
  assign is_b = (op == OP_B);
  assign is_s = (op == OP_S);

  assign pc_inc = pc + 1'b1;
  assign full   = (sp == SP_W'(Stack_Depth));
  assign empty  = (sp == '0);

  // R-type uses its own operand slots; B/S/M share [11:8]/[7:4].
  assign ra_addr = is_r ? instr[R_RS1_HI:R_RS1_LO] : instr[B_RS1_HI:B_RS1_LO];
  assign rb_addr = is_r ? instr[R_RS2_HI:R_RS2_LO] : instr[B_RS2_HI:B_RS2_LO];

  assign dm_raddr = is_s ? {{PAD_D{1'b0}}, rb_data}
                         : instr[M_ADDR_HI:M_ADDR_LO];

  assign s_data =
    ({Data_Width{instr[S_SEL] == S_ENC}} & cus19_enc(dm_rdata, key)) |
    ({Data_Width{instr[S_SEL] == S_DEC}} & cus19_dec(dm_rdata, key));

  assign rs_eq    = (ra_data == rb_data);
  assign br_taken = (instr[B_SEL] == B_BEQ &&  rs_eq) ||
                    (instr[B_SEL] == B_BNE && !rs_eq);

  cus19_imem #(
    .Addr_Width(PC_Width),
    .Word_Width(Instr_Width)
  ) M2 (
    .clk  (clk),
    .we   (1'b0),
    .waddr('0),
    .wdata('0),
    .addr (pc),
    .data (instr)
  );

  cus19_regfile #(
    .Addr_Width(Reg_Addr_Width),
    .Data_Width(Data_Width)
  ) M5 (
    .clk    (clk),
    .ra_addr(ra_addr),
    .rb_addr(rb_addr),
    .ra_data(ra_data),
    .rb_data(rb_data),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  cus19_dmem #(
    .Addr_Width(PC_Width),
    .Data_Width(Data_Width)
  ) M13 (
    .clk  (clk),
    .raddr(dm_raddr),
    .rdata(dm_rdata),
    .we   (dm_we),
    .waddr(dm_waddr),
    .wdata(dm_wdata)
  );

  cus19_alu #(
    .Data_Width(Data_Width)
  ) u_alu (
    .funct (instr[R_FN_HI:R_FN_LO]),
    .a     (ra_data),
    .b     (rb_data),
    .result(alu_res),
    .valid (alu_valid)
  );

  always_comb begin
    pc_next  = pc_inc;
    push     = 1'b0;
    pop      = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = instr[R_RD_HI:R_RD_LO];
    rf_wdata = alu_res[Data_Width-1:0];
    dm_we    = 1'b0;
    dm_waddr = instr[M_ADDR_HI:M_ADDR_LO];
    dm_wdata = rb_data;
    alu_we   = 1'b0;
    ld_we    = 1'b0;
    unique case (1'b1)
      is_r: begin
        rf_we  = alu_valid;
        alu_we = alu_valid;
      end
      is_m: begin
        if (instr[M_SEL] == M_LD) begin
          rf_we    = 1'b1;
          rf_waddr = instr[M_REG_HI:M_REG_LO];
          rf_wdata = dm_rdata;
          ld_we    = 1'b1;
        end else if (instr[M_SEL] == M_ST) begin
          dm_we = 1'b1;
        end
      end
      is_j: begin
        case (instr[J_SUB_HI:J_SUB_LO])
          J_JMP: pc_next = instr[J_TGT_HI:J_TGT_LO];
          J_CALL: begin
            // Full stack degrades CALL to a plain fall-through.
            if (!full) begin
              push    = 1'b1;
              pc_next = instr[J_TGT_HI:J_TGT_LO];
            end
          end
          J_RET: begin
            if (!empty) begin
              pop     = 1'b1;
              pc_next = stack[IDX_W'(sp - 1'b1)];
            end
          end
          J_NOP: pc_next = pc_inc;
          default: pc_next = pc_inc;
        endcase
      end
      is_b: begin
        if (br_taken) begin
          pc_next = {{PAD_B{1'b0}}, instr[B_TGT_HI:B_TGT_LO]};
        end
      end
      is_s: begin
        dm_we    = 1'b1;
        dm_waddr = {{PAD_D{1'b0}}, ra_data};
        dm_wdata = s_data;
      end
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= '0;
      sp             <= '0;
      alu_result_out <= '0;
      ld_result_out  <= '0;
    end else begin
      pc <= pc_next;
      if (push) sp <= sp + 1'b1;
      else if (pop) sp <= sp - 1'b1;
      if (alu_we) alu_result_out <= alu_res;
      if (ld_we) ld_result_out <= {{Data_Width{1'b0}}, dm_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[IDX_W'(sp)] <= pc_inc;
  end

endmodule

// File: tb/tb_cus19_cpu_top.sv
// Bench for cus19_cpu_top: directed programs plus a random program
// checked cycle by cycle against an instruction-level model.
module tb_cus19_cpu_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] alu_o;
  logic [15:0] ld_o;

  cus19_cpu_top dut (
    .cus19_clk_in  (clk),
    .cus19_rst_in  (rst_n),
    .alu_result_out(alu_o),
    .ld_result_out (ld_o)
  );

  always #5 clk = ~clk;

  localparam logic [7:0]  KEY = 8'hA5;
  localparam logic [18:0] NOP = 19'd5;
`ifdef CUS19_ROT_CIPHER_EN
  localparam logic [15:0] ENC_EXP = 16'h0051;
  localparam logic [15:0] DEC_EXP = 16'h00BB;
`else
  localparam logic [15:0] ENC_EXP = 16'h00A8;
  localparam logic [15:0] DEC_EXP = 16'h0099;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [18:0] im [2048];
  logic [7:0]  rf [16];
  logic [7:0]  dm [2048];
  logic [10:0] m_pc;
  logic [10:0] stk [$];
  logic [15:0] m_alu;
  logic [15:0] m_ld;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] r_i(input int rd, input int a,
                                      input int b, input int fn);
    return {rd[3:0], a[3:0], b[3:0], fn[3:0], 3'b000};
  endfunction

  function automatic logic [18:0] m_i(input int addr, input int r,
                                      input int ld);
    return {addr[10:0], r[3:0], ld[0], 3'b001};
  endfunction

  function automatic logic [18:0] j_i(input int tgt, input int sub);
    return {3'b000, tgt[10:0], sub[1:0], 3'b010};
  endfunction

  function automatic logic [18:0] b_i(input int tgt, input int a,
                                      input int b, input int ne);
    return {tgt[6:0], a[3:0], b[3:0], ne[0], 3'b011};
  endfunction

  function automatic logic [18:0] s_i(input int a, input int b,
                                      input int dec);
    return {7'd0, a[3:0], b[3:0], dec[0], 3'b100};
  endfunction

  function automatic logic [7:0] m_enc(input logic [7:0] x);
    int t;
    t = int'(x ^ KEY);
`ifdef CUS19_ROT_CIPHER_EN
    t = ((t * 2) + (t / 128)) % 256;
`endif
    return 8'(t);
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] y);
    int t;
    t = int'(y);
`ifdef CUS19_ROT_CIPHER_EN
    t = (t / 2) + (t % 2) * 128;
`endif
    return 8'(t) ^ KEY;
  endfunction

  task put_im(input int a, input logic [18:0] v);
    im[a[10:0]] = v;
    dut.M2.mem[a[10:0]] <= v;
  endtask

  task put_rf(input int a, input int v);
    rf[a[3:0]] = v[7:0];
    dut.M5.reg_file[a[3:0]] <= v[7:0];
  endtask

  task put_dm(input int a, input int v);
    dm[a[10:0]] = v[7:0];
    dut.M13.data_mem[a[10:0]] <= v[7:0];
  endtask

  task automatic model_step();
    logic [18:0] i;
    logic [10:0] npc;
    int          a;
    int          b;
    int          r;
    logic        ok;
    i   = im[m_pc];
    npc = m_pc + 11'd1;
    case (i[2:0])
      3'd0: begin
        a  = int'(rf[i[14:11]]);
        b  = int'(rf[i[10:7]]);
        ok = 1'b1;
        r  = 0;
        case (i[6:3])
          4'd0: r = a + b;
          4'd1: r = a - b;
          4'd2: r = a * b;
          4'd3: r = a & b;
          4'd4: r = a | b;
          4'd8: r = a ^ b;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          m_alu = 16'(r);
          rf[i[18:15]] = 8'(r);
        end
      end
      3'd1: begin
        if (i[3]) begin
          rf[i[7:4]] = dm[i[18:8]];
          m_ld = {8'h00, dm[i[18:8]]};
        end else begin
          dm[i[18:8]] = rf[i[7:4]];
        end
      end
      3'd2: begin
        case (i[4:3])
          2'd0: npc = i[15:5];
          2'd1: if (stk.size() < 8) begin
            stk.push_back(npc);
            npc = i[15:5];
          end
          2'd2: if (stk.size() > 0) npc = stk.pop_back();
          default: ;
        endcase
      end
      3'd3: if ((rf[i[11:8]] == rf[i[7:4]]) != i[3]) npc = {4'd0, i[18:12]};
      3'd4: begin
        if (i[3]) dm[{3'd0, rf[i[11:8]]}] = m_dec(dm[{3'd0, rf[i[7:4]]}]);
        else      dm[{3'd0, rf[i[11:8]]}] = m_enc(dm[{3'd0, rf[i[7:4]]}]);
      end
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", 16'(dut.pc), 16'(m_pc));
    chk("alu_result", alu_o, m_alu);
    chk("ld_result", ld_o, m_ld);
    chk("stack_depth", 16'(dut.sp), 16'(stk.size()));
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_alu = '0;
    m_ld  = '0;
    stk.delete();
  endtask

  task automatic begin_prog();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2048; i++) put_im(i, NOP);
  endtask

  task automatic go();
    #1;
    rst_n = 1'b1;
  endtask

  logic [18:0] ins;
  logic [3:0]  fns [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_pc", 16'(dut.pc), 16'd0);
    chk("reset_alu", alu_o, 16'd0);
    chk("reset_ld", ld_o, 16'd0);
    chk("reset_sp", 16'(dut.sp), 16'd0);
    for (int i = 0; i < 16; i++) put_rf(i, 0);
    for (int i = 0; i < 2048; i++) put_dm(i, 0);
    @(posedge clk);
    #1;

    begin_prog();
    put_rf(2, 5); put_rf(3, 10); put_rf(7, 200); put_rf(9, 100);
    put_rf(11, 8'h77);
    put_im(0, r_i(4, 2, 3, 2));
    put_im(1, r_i(6, 2, 3, 8));
    put_im(2, r_i(1, 7, 9, 0));
    put_im(3, r_i(5, 2, 3, 1));
    put_im(4, r_i(11, 2, 3, 15));
    go();
    step();
    chk("mul_r4", 16'(dut.M5.reg_file[4]), 16'd50);
    chk("mul_alu", alu_o, 16'h0032);
    step();
    chk("xor_r6", 16'(dut.M5.reg_file[6]), 16'h000F);
    chk("xor_alu", alu_o, 16'h000F);
    step();
    chk("add_carry_alu", alu_o, 16'h012C);
    chk("add_carry_r1", 16'(dut.M5.reg_file[1]), 16'h002C);
    step();
    chk("sub_neg_alu", alu_o, 16'hFFFB);
    step();
    chk("undef_fn_alu", alu_o, 16'hFFFB);
    chk("undef_fn_r11", 16'(dut.M5.reg_file[11]), 16'h0077);

    begin_prog();
    put_dm(0, 15); put_rf(3, 10);
    put_im(0, m_i(0, 8, 1));
    put_im(1, m_i(1, 3, 0));
    go();
    step();
    chk("ld_r8", 16'(dut.M5.reg_file[8]), 16'd15);
    chk("ld_out", ld_o, 16'h000F);
    step();
    chk("st_dmem1", 16'(dut.M13.data_mem[1]), 16'd10);

    begin_prog();
    put_im(4, j_i(7, 0));
    put_im(7, j_i(10, 1));
    put_im(10, j_i(0, 2));
    go();
    repeat (4) step();
    chk("jmp_at", 16'(dut.pc), 16'd4);
    step();
    chk("jmp_pc", 16'(dut.pc), 16'd7);
    step();
    chk("call_pc", 16'(dut.pc), 16'd10);
    step();
    chk("ret_pc", 16'(dut.pc), 16'd8);
    chk("ret_sp", 16'(dut.sp), 16'd0);

    for (int pass = 0; pass < 2; pass++) begin
      begin_prog();
      put_rf(10, 15); put_rf(11, 15);
      put_rf(12, (pass == 0) ? 13 : 15);
      put_im(0, j_i(9, 0));
      put_im(9, b_i(12, 10, 11, 0));
      put_im(12, b_i(15, 11, 12, 1));
      go();
      step();
      step();
      chk("beq_pc", 16'(dut.pc), 16'd12);
      step();
      chk("bne_pc", 16'(dut.pc), (pass == 0) ? 16'd15 : 16'd13);
    end

    begin_prog();
    put_rf(2, 5); put_rf(3, 10); put_rf(14, 15); put_rf(12, 13);
    put_rf(9, 20); put_rf(7, 5);
    put_dm(10, 8'h0D); put_dm(13, 8'h3C);
    put_im(0, s_i(2, 3, 0));
    put_im(1, s_i(14, 12, 1));
    put_im(2, s_i(9, 7, 1));
    go();
    repeat (3) step();
    chk("enc_dmem5", 16'(dut.M13.data_mem[5]), ENC_EXP);
    chk("dec_dmem15", 16'(dut.M13.data_mem[15]), DEC_EXP);
    chk("dec_roundtrip", 16'(dut.M13.data_mem[20]), 16'h000D);

    begin_prog();
    for (int k = 0; k < 9; k++) put_im(2 * k, j_i(2 * k + 2, 1));
    go();
    repeat (9) step();
    chk("call_full_pc", 16'(dut.pc), 16'd17);
    chk("call_full_sp", 16'(dut.sp), 16'd8);

    begin_prog();
    put_im(0, j_i(0, 2));
    put_im(1, j_i(0, 3));
    go();
    step();
    chk("ret_empty_pc", 16'(dut.pc), 16'd1);
    step();
    chk("j_nop_pc", 16'(dut.pc), 16'd2);

    begin_prog();
    put_im(0, j_i(2047, 0));
    go();
    step();
    chk("pc_top", 16'(dut.pc), 16'd2047);
    step();
    chk("pc_wrap", 16'(dut.pc), 16'd0);

    begin_prog();
    for (int i = 0; i < 16; i++) put_rf(i, int'($urandom_range(0, 255)));
    for (int i = 0; i < 2048; i++) put_dm(i, int'($urandom_range(0, 255)));
    for (int k = 0; k < 128; k++) begin
      ins = 19'($urandom);
      ins[2:0] = 3'($urandom_range(0, 5));
      if (ins[2:0] == 3'd2) ins[15:5] = 11'($urandom_range(0, 127));
      if (ins[2:0] == 3'd0 && $urandom_range(0, 3) != 0)
        ins[6:3] = fns[$urandom_range(0, 5)];
      put_im(k, ins);
    end
    go();
    repeat (400) step();
    for (int i = 0; i < 16; i++)
      chk("rand_reg", 16'(dut.M5.reg_file[i]), 16'(rf[i]));
    for (int i = 0; i < 2048; i++)
      chk("rand_dmem", 16'(dut.M13.data_mem[i]), 16'(dm[i]));

    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrun_pc", 16'(dut.pc), 16'd0);
    chk("midrun_alu", alu_o, 16'd0);
    chk("midrun_ld", ld_o, 16'd0);
    chk("midrun_sp", 16'(dut.sp), 16'd0);
    chk("midrun_reg", 16'(dut.M5.reg_file[5]), 16'(rf[5]));
    chk("midrun_dmem", 16'(dut.M13.data_mem[77]), 16'(dm[77]));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
